alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Front-end controller that sits directly upstream and downstream of the N-bit ALU on the lab board.
- Collects operand A, operand B and the 4-bit alucontrol code from the board switches, one step per debounced button press.
- Presents the captured operands and code to the ALU, then registers the ALU result and its 4 flags for the 7-segment display and LEDs.
- Contains the only sequential logic in the ALU datapath; the ALU itself stays purely combinational.

Parameters:
- N, 4, operand/result width; must match the ALU's N.
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples required before the button level is accepted; must be at least 2.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous, active-low reset.
- sw_i  input  N  operand switches, asynchronous to clk_i.
- op_sw_i  input  4  alucontrol switches, asynchronous to clk_i.
- next_btn_i  input  1  raw "next" pushbutton, active-high, bouncy.
- a_o  output  N  registered operand A to the ALU.
- b_o  output  N  registered operand B to the ALU.
- alucontrol_o  output  4  registered operation code to the ALU.
- result_i  input  N  combinational result from the ALU.
- flags_i  input  4  ALU flags {C,Ne,V,Z}; bit 3 is C, bit 0 is Z.
- display_o  output  N  value sent to the 7-segment driver.
- flags_o  output  4  registered flags {C,Ne,V,Z} for the LEDs.
- state_o  output  3  current FSM state encoding, for the status LEDs.
- valid_o  output  1  high while a registered result is being shown.

Behaviour:
- Reset (asynchronous, any state): a_o, b_o, alucontrol_o, flags_o, the result register and valid_o are all 0; state is S_LOAD_A; the debouncer's stable level and counter are 0.
- Synchronization: sw_i and op_sw_i are sampled only on capture edges. next_btn_i passes through a 2-FF synchronizer before the debouncer.
- Debounce:
  - The counter increments while the synchronized level differs from the stable level, and clears to 0 when they agree.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter clears.
  - press is a 1-cycle pulse on the rising edge of the stable level.
  - A held button produces exactly one press. The release is debounced the same way and produces no pulse.
- FSM (state_o encoding: S_LOAD_A=0, S_LOAD_B=1, S_LOAD_OP=2, S_EXEC=3, S_SHOW=4):
  - S_LOAD_A: display_o = sw_i (live). On press: a_o <= sw_i, go to S_LOAD_B.
  - S_LOAD_B: display_o = sw_i. On press: b_o <= sw_i, go to S_LOAD_OP.
  - S_LOAD_OP: display_o = zero-extended op_sw_i (truncated to N bits if N<4). On press: alucontrol_o <= op_sw_i, go to S_EXEC.
  - S_EXEC: exactly 1 cycle and ignores press. Operands are already stable, so at the end of the cycle: result register <= result_i, flags_o <= flags_i, valid_o <= 1, go to S_SHOW. display_o = result register (previous value).
  - S_SHOW: display_o = result register. On press: valid_o <= 0, go to S_LOAD_A. a_o, b_o and alucontrol_o hold their values until overwritten.
  - Encodings 5-7 are unreachable; if entered, go to S_LOAD_A on the next clock.
- Latency: from the press pulse in S_LOAD_OP, the result is registered 2 cycles later (1 cycle to reach S_EXEC, then the S_EXEC capture).
- Opcode pass-through: all 16 codes are captured unchanged, including codes the ALU does not implement. The sequencer does not interpret them.
- Width: no arithmetic in this block; all captures are straight register loads.
- Simultaneous events: a press arriving in the same cycle as a state transition is consumed by the current state only. No press is queued.
- Reset mid-operation (e.g. in S_LOAD_B): all captured values are discarded and the sequence restarts at S_LOAD_A.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum typedef (3-bit) and its encoding;
  - localparams for the opcodes: ADD=0, SUB=1, AND=2, OR=3, NOT=4, XOR=5, SLL=6, SLA=7, SRL=8, SRA=9;
  - localparams for the flag bit indices: C=3, NE=2, V=1, Z=0.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk_i, rst_n_i, btn_i, press_o) contains the synchronizer, the counter and the edge detector. It is instantiated once.

Test Plan:
- Bench setup: N=4, DEBOUNCE_CYCLES=4, real ALU instantiated in the bench.
- Add: A=3, B=4, op=0 with clean presses -> in S_SHOW: display_o=7, flags_o=4'b0000, valid_o=1, state_o=4.
- Subtract to zero: A=5, B=5, op=1 -> display_o=0, flags_o[0] (Z)=1, flags_o[2] (Ne)=0.
- Bounce rejection: in S_LOAD_A, toggle next_btn_i with pulses of 1-3 cycles for 40 cycles -> state_o stays 0 and a_o is unchanged. A clean press then produces exactly one transition.
- Held button: hold next_btn_i high for 200 cycles in S_LOAD_B -> exactly one advance to S_LOAD_OP; b_o equals sw_i at the press.
- Reset mid-sequence: assert rst_n_i=0 asynchronously (off clock edge) while in S_LOAD_OP with a_o=9 -> immediately a_o=0, b_o=0, alucontrol_o=0, flags_o=0, valid_o=0, state_o=0.
- Unused opcode and wrap: op=4'b1111 -> alucontrol_o=15 reaches the ALU, S_EXEC lasts 1 cycle, S_SHOW is reached. A press in S_SHOW returns to S_LOAD_A with valid_o=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Includes the state encoding, the opcode values and the flag bit positions.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SLA = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    localparam int FLAG_C  = 3;
    localparam int FLAG_NE = 2;
    localparam int FLAG_V  = 1;
    localparam int FLAG_Z  = 0;

endpackage

// File: rtl/alu_operand_sequencer_debounce.sv
// Button front end: a 2-FF synchronizer, a stability counter and a rising-edge pulse.
// The counter only advances while the synchronized level differs from the accepted one.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync[1] != stable) && (cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync    <= '0;
            stable  <= 1'b0;
            cnt     <= '0;
            press_o <= 1'b0;
        end else begin
            sync    <= {sync[0], btn_i};
            // The pulse coincides with the cycle the stable level turns high.
            press_o <= flip && sync[1];
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (flip) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps operand A, operand B and the opcode into registers for the ALU on each press,
// then latches the ALU result and flags for the display and LEDs.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [N-1:0] sw_i,
    input  logic [3:0]   op_sw_i,
    input  logic         next_btn_i,
    output logic [N-1:0] a_o,
    output logic [N-1:0] b_o,
    output logic [3:0]   alucontrol_o,
    input  logic [N-1:0] result_i,
    input  logic [3:0]   flags_i,
    output logic [N-1:0] display_o,
    output logic [3:0]   flags_o,
    output logic [2:0]   state_o,
    output logic         valid_o
);

    state_t       state;
    logic         press;
    logic [N-1:0] result;
    logic [N+3:0] op_ext;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .btn_i   (next_btn_i),
        .press_o (press)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_LOAD_A;
            a_o          <= '0;
            b_o          <= '0;
            alucontrol_o <= '0;
            result       <= '0;
            flags_o      <= '0;
            valid_o      <= 1'b0;
        end else begin
            case (state)
                S_LOAD_A: if (press) begin
                    a_o   <= sw_i;
                    state <= S_LOAD_B;
                end
                S_LOAD_B: if (press) begin
                    b_o   <= sw_i;
                    state <= S_LOAD_OP;
                end
                S_LOAD_OP: if (press) begin
                    alucontrol_o <= op_sw_i;
                    state        <= S_EXEC;
                end
                // Operands have been on the ALU inputs for a full cycle already.
                S_EXEC: begin
                    result  <= result_i;
                    flags_o <= flags_i;
                    valid_o <= 1'b1;
                    state   <= S_SHOW;
                end
                S_SHOW: if (press) begin
                    valid_o <= 1'b0;
                    state   <= S_LOAD_A;
                end
                default: state <= S_LOAD_A;
            endcase
        end
    end

    assign op_ext  = {{N{1'b0}}, op_sw_i};
    assign state_o = state;

    always_comb begin
        display_o = result;
        case (state)
            S_LOAD_A, S_LOAD_B: display_o = sw_i;
            S_LOAD_OP:          display_o = op_ext[N-1:0];
            default:            display_o = result;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a behavioural 4-bit ALU closing the loop.
// Expected ALU outputs are queued at the opcode press and popped when valid_o rises.
module tb_alu_operand_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = '0, op_sw = '0;
    logic       btn = 1'b0;
    logic [3:0] a, b, alucontrol, result, flags, display, flags_q;
    logic [2:0] state;
    logic       valid;

    int checks = 0, errors = 0;
    logic [7:0] sb_q[$];
    logic [3:0] a_sw, b_sw;
    logic [2:0] prev_state = '0;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.N(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .sw_i(sw), .op_sw_i(op_sw), .next_btn_i(btn),
        .a_o(a), .b_o(b), .alucontrol_o(alucontrol), .result_i(result), .flags_i(flags),
        .display_o(display), .flags_o(flags_q), .state_o(state), .valid_o(valid)
    );

    // Returns {flags C,Ne,V,Z, result}.
    function automatic logic [7:0] alu_f(input logic [3:0] x, input logic [3:0] y, input logic [3:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        c = 1'b0; v = 1'b0; r = '0; s = '0;
        case (op)
            OP_ADD: begin s = {1'b0, x} + {1'b0, y}; r = s[3:0]; c = s[4];
                          v = (x[3] == y[3]) && (r[3] != x[3]); end
            OP_SUB: begin s = {1'b0, x} + {1'b0, ~y} + 5'd1; r = s[3:0]; c = s[4];
                          v = (x[3] != y[3]) && (r[3] != x[3]); end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_NOT: r = ~x;
            OP_XOR: r = x ^ y;
            OP_SLL, OP_SLA: r = x << y[1:0];
            OP_SRL: r = x >> y[1:0];
            OP_SRA: r = 4'($signed(x) >>> y[1:0]);
            default: r = '0;
        endcase
        return {c, r[3], v, (r == 4'd0), r};
    endfunction

    always_comb {flags, result} = alu_f(a, b, alucontrol);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on valid rising; also S_EXEC must last exactly one cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && !prev_valid) begin
                if (sb_q.size() == 0) chk("sb_empty_pop", 1, 0);
                else begin
                    logic [7:0] e;
                    e = sb_q.pop_front();
                    chk("sb_display", {28'd0, display}, {28'd0, e[3:0]});
                    chk("sb_flags", {28'd0, flags_q}, {28'd0, e[7:4]});
                end
            end
            if (prev_state == 3'd3) chk("exec_len", {29'd0, state}, 32'd4);
        end
        prev_state = state;
        prev_valid = valid;
    end

    task automatic press_btn();
        @(negedge clk) btn = 1'b1;
        repeat (10) @(negedge clk);
        btn = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state != s && n < 100) begin @(negedge clk); n++; end
        chk(tag, {29'd0, state}, {29'd0, s});
    endtask

    task automatic load_ab(input logic [3:0] x, input logic [3:0] y);
        sw = x; a_sw = x; press_btn();
        chk("st_after_a", {29'd0, state}, 32'd1);
        sw = y; b_sw = y; press_btn();
        chk("st_after_b", {29'd0, state}, 32'd2);
    endtask

    task automatic load_op(input logic [3:0] op);
        op_sw = op;
        sb_q.push_back(alu_f(a_sw, b_sw, op));
        press_btn();
        wait_state(3'd4, "reach_show");
    endtask

    initial begin
        int t, h, l, adv;
        repeat (3) @(negedge clk);
        chk("rst_state", {29'd0, state}, 0);
        chk("rst_a", {28'd0, a}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_flags", {28'd0, flags_q}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Add 3+4
        load_ab(4'd3, 4'd4);
        load_op(OP_ADD);
        chk("add_disp", {28'd0, display}, 7);
        chk("add_flags", {28'd0, flags_q}, 0);
        chk("add_valid", {31'd0, valid}, 1);
        chk("add_a", {28'd0, a}, 3);
        chk("add_b", {28'd0, b}, 4);
        press_btn();
        chk("show_exit", {29'd0, state}, 0);

        // Subtract to zero
        load_ab(4'd5, 4'd5);
        load_op(OP_SUB);
        chk("sub_disp", {28'd0, display}, 0);
        chk("sub_z", {31'd0, flags_q[FLAG_Z]}, 1);
        chk("sub_ne", {31'd0, flags_q[FLAG_NE]}, 0);
        press_btn();

        // Bounce rejection in S_LOAD_A (a_o currently 5)
        sw = 4'd6; a_sw = 4'd6;
        t = 0;
        while (t < 40) begin
            h = $urandom_range(1, 3); l = $urandom_range(1, 3);
            btn = 1'b1; repeat (h) @(negedge clk);
            btn = 1'b0; repeat (l) @(negedge clk);
            t += h + l;
        end
        repeat (10) @(negedge clk);
        chk("bounce_state", {29'd0, state}, 0);
        chk("bounce_a", {28'd0, a}, 5);
        press_btn();
        chk("bounce_press_state", {29'd0, state}, 1);
        chk("bounce_press_a", {28'd0, a}, 6);

        // Held button in S_LOAD_B
        sw = 4'd10; b_sw = 4'd10; adv = 0;
        @(negedge clk) btn = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prev_state != state) adv++;
            if (state == 3'd2) sw = 4'd2;
        end
        btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_adv", adv, 1);
        chk("held_state", {29'd0, state}, 2);
        chk("held_b", {28'd0, b}, 10);
        load_op(OP_XOR);
        press_btn();

        // Asynchronous reset while in S_LOAD_OP
        load_ab(4'd9, 4'd3);
        chk("pre_rst_a", {28'd0, a}, 9);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_a", {28'd0, a}, 0);
        chk("arst_b", {28'd0, b}, 0);
        chk("arst_op", {28'd0, alucontrol}, 0);
        chk("arst_flags", {28'd0, flags_q}, 0);
        chk("arst_valid", {31'd0, valid}, 0);
        chk("arst_state", {29'd0, state}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unimplemented opcode passes through unchanged
        load_ab(4'd7, 4'd1);
        load_op(4'hF);
        chk("op15_ctrl", {28'd0, alucontrol}, 15);
        chk("op15_valid", {31'd0, valid}, 1);
        press_btn();
        chk("op15_exit_state", {29'd0, state}, 0);
        chk("op15_exit_valid", {31'd0, valid}, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
